// File: rtl/eth_mac_gmii_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module  : eth_mac_gmii_tx_framer_if
// Purpose : AXI-Stream style byte bus feeding the GMII transmit framer.
// Ports   : tdata  - payload byte          tvalid - source has a beat
//           tready - sink accepts the beat  tlast  - final beat of frame
//           tuser  - bad-frame mark (meaningful on the tlast beat only)
// Modports: master (source side), slave (framer side)
// Revision: 1.0 - initial release
// ============================================================================
interface eth_mac_gmii_tx_framer_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/eth_mac_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : eth_mac_gmii_tx_framer
// Purpose : Turns an 8-bit Ethernet frame stream into a GMII transmit stream:
//           7x 0x55 preamble, 0xD5 SFD, frame, optional zero pad, CRC-32 FCS
//           (LSB byte first), then a forced inter-frame gap.
// Ports   : clk           - byte clock
//           reset         - asynchronous, active-high
//           tx_axis_if    - frame byte stream (slave modport)
//           gmii_txd      - transmit data (registered)
//           gmii_tx_en    - transmit enable (registered)
//           gmii_tx_er    - transmit error (registered)
//           busy          - frame in progress, including the gap
//           err_underflow - one-cycle pulse when the source starves mid-frame
// Config  : ETH_TX_PAD_EN - when defined, short frames are zero-padded up to
//           MIN_FRAME_LENGTH-4 bytes before the FCS.
// Revision: 1.0 - initial release
// ============================================================================
module eth_mac_gmii_tx_framer #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_BYTES        = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  eth_mac_gmii_tx_framer_if.slave         tx_axis_if,
  output logic [7:0]                      gmii_txd,
  output logic                            gmii_tx_en,
  output logic                            gmii_tx_er,
  output logic                            busy,
  output logic                            err_underflow
);

  // Output registers are loaded from the decode of the current state, so a
  // state's action appears on the wire one cycle later. The gap state
  // therefore runs one extra cycle to cover the last FCS byte still on the
  // wire, giving IFG_BYTES idle cycles plus the IDLE cycle between frames.
  localparam logic [15:0] c_ifg_last = 16'(IFG_BYTES);
`ifdef ETH_TX_PAD_EN
  localparam logic [15:0] c_pad_target = 16'(MIN_FRAME_LENGTH - 4);
`endif

  if (MIN_FRAME_LENGTH < 5 || IFG_BYTES < 1) begin : g_param_check
    $error("eth_mac_gmii_tx_framer: MIN_FRAME_LENGTH must be >= 5 and IFG_BYTES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREAMBLE  = 3'd1,
    S_PAYLOAD   = 3'd2,
    S_FCS       = 3'd3,
    S_UNDERFLOW = 3'd4,
    S_DISCARD   = 3'd5,
    S_IFG       = 3'd6
`ifdef ETH_TX_PAD_EN
   ,S_PAD       = 3'd7
`endif
  } state_t;

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;       // frame bytes so far (data + pad), saturating
  logic [15:0] r_sub, w_sub;       // preamble / FCS / gap step counter
  logic [31:0] r_crc, w_crc;
  logic        r_bad, w_bad;       // tuser seen on the tlast beat
  logic [7:0]  r_txd, w_txd;
  logic        r_tx_en, w_tx_en;
  logic        r_tx_er, w_tx_er;
  logic        r_err_uf, w_err_uf;
  logic        w_tready;
  logic [15:0] w_cnt_inc;
  logic [7:0]  w_fcs;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  always_comb begin
    w_fcs = 8'h00;
    case (r_sub[1:0])
      2'd0:    w_fcs = ~r_crc[7:0];
      2'd1:    w_fcs = ~r_crc[15:8];
      2'd2:    w_fcs = ~r_crc[23:16];
      default: w_fcs = ~r_crc[31:24];
    endcase
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_sub    = r_sub;
    w_crc    = r_crc;
    w_bad    = r_bad;
    w_txd    = 8'h00;
    w_tx_en  = 1'b0;
    w_tx_er  = 1'b0;
    w_err_uf = 1'b0;
    w_tready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_crc = 32'hFFFFFFFF;
        w_cnt = 16'd0;
        w_sub = 16'd0;
        w_bad = 1'b0;
        if (tx_axis_if.tvalid) begin
          // First preamble byte goes out straight away; the beat waits.
          w_state = S_PREAMBLE;
          w_txd   = 8'h55;
          w_tx_en = 1'b1;
        end
      end
      S_PREAMBLE: begin
        w_tx_en = 1'b1;
        w_sub   = r_sub + 16'd1;
        if (r_sub == 16'd6) begin
          w_txd   = 8'hD5;
          w_sub   = 16'd0;
          w_state = S_PAYLOAD;
        end else begin
          w_txd = 8'h55;
        end
      end
      S_PAYLOAD: begin
        w_tready = 1'b1;
        w_tx_en  = 1'b1;
        if (tx_axis_if.tvalid) begin
          w_txd = tx_axis_if.tdata;
          w_crc = crc_step(r_crc, tx_axis_if.tdata);
          w_cnt = w_cnt_inc;
          if (tx_axis_if.tlast) begin
            w_bad   = tx_axis_if.tuser[0];
            w_sub   = 16'd0;
            w_state = S_FCS;
`ifdef ETH_TX_PAD_EN
            if (w_cnt_inc < c_pad_target) w_state = S_PAD;
`endif
          end
        end else begin
          w_tx_er  = 1'b1;
          w_err_uf = 1'b1;
          w_state  = S_UNDERFLOW;
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        w_tx_en = 1'b1;
        w_crc   = crc_step(r_crc, 8'h00);
        w_cnt   = w_cnt_inc;
        if (w_cnt_inc >= c_pad_target) begin
          w_sub   = 16'd0;
          w_state = S_FCS;
        end
      end
`endif
      S_FCS: begin
        w_tx_en = 1'b1;
        w_tx_er = r_bad;
        w_txd   = w_fcs;
        w_sub   = r_sub + 16'd1;
        if (r_sub == 16'd3) begin
          w_sub   = 16'd0;
          w_state = S_IFG;
        end
      end
      S_UNDERFLOW, S_DISCARD: begin
        // Drop the rest of the starved frame; a tlast beat ends it.
        w_tready = 1'b1;
        w_sub    = 16'd0;
        if (tx_axis_if.tvalid && tx_axis_if.tlast) w_state = S_IFG;
        else                                       w_state = S_DISCARD;
      end
      S_IFG: begin
        w_sub = r_sub + 16'd1;
        if (r_sub == c_ifg_last) begin
          w_sub   = 16'd0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_sub    <= 16'd0;
      r_crc    <= 32'hFFFFFFFF;
      r_bad    <= 1'b0;
      r_txd    <= 8'h00;
      r_tx_en  <= 1'b0;
      r_tx_er  <= 1'b0;
      r_err_uf <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_sub    <= w_sub;
      r_crc    <= w_crc;
      r_bad    <= w_bad;
      r_txd    <= w_txd;
      r_tx_en  <= w_tx_en;
      r_tx_er  <= w_tx_er;
      r_err_uf <= w_err_uf;
    end
  end

  assign tx_axis_if.tready = w_tready;
  assign gmii_txd          = r_txd;
  assign gmii_tx_en        = r_tx_en;
  assign gmii_tx_er        = r_tx_er;
  assign err_underflow     = r_err_uf;
  assign busy              = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_mac_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_mac_gmii_tx_framer
// Purpose : Self-checking bench for eth_mac_gmii_tx_framer. Expected GMII
//           beats are queued when a frame is driven and compared as the DUT
//           transmits; frame lengths, gaps and latency are checked per test.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_mac_gmii_tx_framer;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, busy, err_underflow;

  eth_mac_gmii_tx_framer_if #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) axis ();

  eth_mac_gmii_tx_framer #(.MIN_FRAME_LENGTH(64), .IFG_BYTES(12)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_axis_if    (axis),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic er; } beat_t;
  beat_t      exp_q[$];
  int         runs[$];
  int         gaps[$];
  int         n_cmp = 0, n_err = 0;
  int         cyc = 0, uf_pulses = 0;
  int         t_start = 0, t_rise = 0, t_pl = 0;
  logic [7:0] fbuf [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic fb;
    for (int j = 0; j < 8; j++) begin
      fb = d[j] ^ c[0];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic push(input logic [7:0] d, input logic er);
    beat_t b;
    b.d = d; b.er = er;
    exp_q.push_back(b);
  endtask

  // Expected wire image of a frame held in fbuf.
  task automatic push_frame(input int len, input logic bad, input int uf_at);
    int          plen;
    logic [31:0] c;
    logic [7:0]  b;
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    if (uf_at >= 0) begin
      for (int i = 0; i < uf_at; i++) push(fbuf[i], 1'b0);
      push(8'h00, 1'b1);
    end else begin
      plen = (PAD_EN && len < 60) ? 60 : len;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < plen; i++) begin
        b = (i < len) ? fbuf[i] : 8'h00;
        push(b, 1'b0);
        c = ref_crc(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) push(c[8*k +: 8], bad);
    end
  endtask

  task automatic fill(input int len, input int seed);
    for (int i = 0; i < len; i++) fbuf[i] = 8'((i * 37 + seed * 11 + 5) ^ $urandom_range(0, 255));
  endtask

  // Drives one frame from fbuf. uf_at: beat index preceded by a one-cycle
  // tvalid drop. rst_at: beat index after which reset is asserted.
  task automatic send_frame(input int len, input logic bad, input int uf_at, input int rst_at);
    int t;
    for (int i = 0; i < len; i++) begin
      if (i == uf_at) begin
        axis.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      axis.tdata  = fbuf[i];
      axis.tvalid = 1'b1;
      axis.tlast  = (i == len - 1);
      axis.tuser  = (i == len - 1) ? bad : 1'(i & 1);
      if (i == 0) t_start = cyc;
      t = 0;
      while (!axis.tready && t < 1000) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 1000) begin
        chk("tready_timeout", 32'd0, 32'd1);
        axis.tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i == rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_txd", {24'd0, gmii_txd}, 32'd0);
        chk("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
        chk("rst_tx_er", {31'd0, gmii_tx_er}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tready", {31'd0, axis.tready}, 32'd0);
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while ((busy || gmii_tx_en || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {31'd0, (t < 3000)}, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_run(input string tag, input int exp);
    if (runs.size() == 0) chk(tag, 32'hFFFFFFFF, 32'(exp));
    else                  chk(tag, 32'(runs.pop_front()), 32'(exp));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: compares every tx_en beat against the scoreboard.
  initial begin
    logic  prev_en = 1'b0;
    bit    seen_fall = 1'b0;
    int    run_len = 0, gap_cnt = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (err_underflow) uf_pulses++;
      if (gmii_tx_en) begin
        if (!prev_en) begin
          t_rise = cyc;
          if (seen_fall) gaps.push_back(gap_cnt);
          run_len = 0;
        end
        if (run_len == 8) t_pl = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_beat", {24'd0, gmii_txd}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("txd", {24'd0, gmii_txd}, {24'd0, e.d});
          chk("tx_er", {31'd0, gmii_tx_er}, {31'd0, e.er});
        end
        run_len++;
      end else begin
        if (prev_en) begin
          runs.push_back(run_len);
          seen_fall = 1'b1;
          gap_cnt = 0;
        end
        gap_cnt++;
        chk("idle_tx_er", {31'd0, gmii_tx_er}, 32'd0);
      end
      prev_en = gmii_tx_en;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    axis.tdata = 8'h00; axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", {24'd0, gmii_txd}, 32'd0);
    chk("reset_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_uf", {31'd0, err_underflow}, 32'd0);
    chk("reset_tready", {31'd0, axis.tready}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: "123456789", known FCS 26 39 F4 CB when unpadded
    for (int i = 0; i < 9; i++) fbuf[i] = 8'(8'h31 + i);
`ifdef ETH_TX_PAD_EN
    push_frame(9, 1'b0, -1);
`else
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    for (int i = 0; i < 9; i++) push(8'(8'h31 + i), 1'b0);
    push(8'h26, 1'b0); push(8'h39, 1'b0); push(8'hF4, 1'b0); push(8'hCB, 1'b0);
`endif
    send_frame(9, 1'b0, -1, -1);
    wait_done("t1_done");
    chk_run("t1_tx_en_len", PAD_EN ? 72 : 21);
    chk("t1_lat_preamble", 32'(t_rise - t_start), 32'd1);
    chk("t1_lat_payload", 32'(t_pl - t_start), 32'd9);

    // 2: short 14-byte frame
    fill(14, 2);
    push_frame(14, 1'b0, -1);
    send_frame(14, 1'b0, -1, -1);
    wait_done("t2_done");
    chk_run("t2_tx_en_len", PAD_EN ? 72 : 26);

    // 3: two 64-byte frames back to back
    gaps.delete();
    fill(64, 3);
    push_frame(64, 1'b0, -1);
    send_frame(64, 1'b0, -1, -1);
    fill(64, 4);
    push_frame(64, 1'b0, -1);
    send_frame(64, 1'b0, -1, -1);
    wait_done("t3_done");
    chk_run("t3_len_a", 76);
    chk_run("t3_len_b", 76);
    chk("t3_gap", (gaps.size() > 0) ? 32'(gaps[$]) : 32'hFFFFFFFF, 32'd13);

    // 4: underflow at byte 20 of 100, then a clean frame
    uf_pulses = 0;
    fill(100, 5);
    push_frame(100, 1'b0, 20);
    send_frame(100, 1'b0, 20, -1);
    wait_done("t4_done");
    chk_run("t4_tx_en_len", 29);
    chk("t4_uf_pulses", 32'(uf_pulses), 32'd1);
    fill(60, 6);
    push_frame(60, 1'b0, -1);
    send_frame(60, 1'b0, -1, -1);
    wait_done("t4b_done");
    chk_run("t4b_tx_en_len", 72);

    // 5: bad frame marked on tlast
    fill(60, 7);
    push_frame(60, 1'b1, -1);
    send_frame(60, 1'b1, -1, -1);
    wait_done("t5_done");
    chk_run("t5_tx_en_len", 72);
    chk("t5_uf_pulses", 32'(uf_pulses), 32'd1);

    // 6: reset during payload, then a clean frame
    fill(64, 8);
    push_frame(64, 1'b0, -1);
    send_frame(64, 1'b0, -1, 30);
    @(negedge clk);
    @(negedge clk);
    runs.delete();
    fill(64, 9);
    push_frame(64, 1'b0, -1);
    send_frame(64, 1'b0, -1, -1);
    wait_done("t6_done");
    chk_run("t6_tx_en_len", 76);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
